// File: rtl/riscv_core_decode_pkg.sv
// Shared opcodes, field encodings and the packed control bundle for the decode stage.
package riscv_core_decode_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_AMO       = 7'b0101111;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [4:0] F5_LR = 5'b00010;
  localparam logic [4:0] F5_SC = 5'b00011;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;
  localparam logic [1:0] RES_CSR = 2'd3;

  localparam logic [1:0] CSR_NONE = 2'd0;
  localparam logic [1:0] CSR_RW   = 2'd1;
  localparam logic [1:0] CSR_RS   = 2'd2;
  localparam logic [1:0] CSR_RC   = 2'd3;

  localparam logic [3:0] AMO_NONE = 4'd0;
  localparam logic [3:0] AMO_ADD  = 4'd1;
  localparam logic [3:0] AMO_SWAP = 4'd2;
  localparam logic [3:0] AMO_XOR  = 4'd3;
  localparam logic [3:0] AMO_AND  = 4'd4;
  localparam logic [3:0] AMO_OR   = 4'd5;
  localparam logic [3:0] AMO_MIN  = 4'd6;
  localparam logic [3:0] AMO_MAX  = 4'd7;
  localparam logic [3:0] AMO_MINU = 4'd8;
  localparam logic [3:0] AMO_MAXU = 4'd9;

  typedef struct packed {
    logic       regwrite;
    logic [2:0] imsrc;
    logic       uctrl;
    logic       alusrcb;
    logic       memwrite;
    logic [1:0] resultsrc;
    logic       branch;
    logic       aluop;
    logic [1:0] size;
    logic       ldext;
    logic       isword;
    logic       jump;
    logic       bjreg;
    logic       imsel;
    logic       new_mux_sel;
    logic       amo;
    logic [3:0] amo_op;
    logic       lr;
    logic       sc;
    logic       src_sel;
    logic [1:0] csr_op;
    logic       read;
    logic       illegal;
  } decode_ctrl_t;

  localparam decode_ctrl_t CTRL_NOP = '0;

  // Read-modify-write AMOs only; LR/SC and undefined funct5 map to AMO_NONE.
  function automatic logic [3:0] amo_op_of(input logic [4:0] funct5);
    case (funct5)
      5'b00000: return AMO_ADD;
      5'b00001: return AMO_SWAP;
      5'b00100: return AMO_XOR;
      5'b01100: return AMO_AND;
      5'b01000: return AMO_OR;
      5'b10000: return AMO_MIN;
      5'b10100: return AMO_MAX;
      5'b11000: return AMO_MINU;
      5'b11100: return AMO_MAXU;
      default:  return AMO_NONE;
    endcase
  endfunction

endpackage

// File: rtl/riscv_core_decode_logic.sv
// Combinational RISC-V instruction decoder producing the packed control bundle.
module riscv_core_decode_logic
  import riscv_core_decode_pkg::*;
#(
  parameter int XLEN = 64,
  parameter bit EN_M = 1'b1,
  parameter bit EN_A = 1'b1
) (
  input  logic [31:0]  instr,
  output decode_ctrl_t ctrl
);

  localparam bit IS64 = (XLEN == 64);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [4:0] funct5;
  logic [2:0] funct3;
  logic       is_lr;
  logic       is_sc;
  logic       bad;
  logic       unused_fields;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign funct5 = instr[31:27];
  assign is_lr  = (funct5 == F5_LR);
  assign is_sc  = (funct5 == F5_SC);
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    // NOTE: the bundle and the illegal flag get defaults before the case, so no path infers a latch.
    ctrl = CTRL_NOP;
    bad  = 1'b0;
    case (opcode)
      OPC_LUI: begin
        ctrl.regwrite    = 1'b1;
        ctrl.imsrc       = IMM_U;
        ctrl.new_mux_sel = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl.regwrite = 1'b1;
        ctrl.imsrc    = IMM_U;
        ctrl.uctrl    = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        ctrl.regwrite  = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.resultsrc = RES_PC4;
        ctrl.bjreg     = (opcode == OPC_JALR);
        ctrl.alusrcb   = (opcode == OPC_JALR);
        ctrl.imsrc     = (opcode == OPC_JAL) ? IMM_J : IMM_I;
      end
      OPC_BRANCH: begin
        ctrl.imsrc  = IMM_B;
        ctrl.branch = 1'b1;
      end
      OPC_LOAD: begin
        ctrl.regwrite  = 1'b1;
        ctrl.alusrcb   = 1'b1;
        ctrl.resultsrc = RES_MEM;
        ctrl.size      = funct3[1:0];
        ctrl.ldext     = funct3[2];
        ctrl.read      = 1'b1;
        bad = (funct3 == 3'b111) || (!IS64 && (funct3 == 3'b011 || funct3 == 3'b110));
      end
      OPC_STORE: begin
        ctrl.imsrc    = IMM_S;
        ctrl.alusrcb  = 1'b1;
        ctrl.memwrite = 1'b1;
        ctrl.size     = funct3[1:0];
        bad = funct3[2] || (!IS64 && funct3 == 3'b011);
      end
      OPC_OP_IMM, OPC_OP_IMM_32: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrcb  = 1'b1;
        ctrl.aluop    = 1'b1;
        ctrl.isword   = (opcode == OPC_OP_IMM_32);
        bad = (opcode == OPC_OP_IMM_32) && !IS64;
      end
      OPC_OP: begin
        ctrl.regwrite = 1'b1;
        ctrl.aluop    = 1'b1;
        ctrl.imsel    = (funct7 == F7_MULDIV);
        bad = !((funct7 == F7_BASE) || (funct7 == F7_ALT) || (EN_M && funct7 == F7_MULDIV));
      end
      OPC_OP_32: begin
        ctrl.regwrite = 1'b1;
        ctrl.aluop    = 1'b1;
        ctrl.isword   = 1'b1;
        ctrl.imsel    = (funct7 == F7_MULDIV);
        bad = !IS64 || (!EN_M && funct7 == F7_MULDIV);
      end
      OPC_AMO: begin
        ctrl.regwrite  = 1'b1;
        ctrl.resultsrc = RES_MEM;
        ctrl.size      = funct3[1:0];
        ctrl.lr        = is_lr;
        ctrl.sc        = is_sc;
        ctrl.amo       = !(is_lr || is_sc);
        ctrl.amo_op    = amo_op_of(funct5);
        ctrl.memwrite  = !is_lr;
        ctrl.read      = !is_sc;
        bad = !EN_A || !(funct3 == 3'b010 || funct3 == 3'b011) ||
              (funct3 == 3'b011 && !IS64) ||
              (amo_op_of(funct5) == AMO_NONE && !is_lr && !is_sc);
      end
      OPC_SYSTEM: begin
        // funct3[1:0] is the CSR operation, funct3[2] selects the zero-extended uimm source.
        ctrl.regwrite  = (funct3[1:0] != CSR_NONE);
        ctrl.resultsrc = RES_CSR;
        ctrl.csr_op    = funct3[1:0];
        ctrl.src_sel   = funct3[2];
      end
      OPC_MISC_MEM: ;
      default: bad = 1'b1;
    endcase

    ctrl.illegal = bad;
    if (bad) begin
      ctrl.regwrite = 1'b0;
      ctrl.memwrite = 1'b0;
      ctrl.branch   = 1'b0;
      ctrl.jump     = 1'b0;
      ctrl.amo      = 1'b0;
      ctrl.lr       = 1'b0;
      ctrl.sc       = 1'b0;
      ctrl.read     = 1'b0;
    end
  end

endmodule

// File: rtl/riscv_core_decode_stage.sv
// Registered decode stage: decodes on accept, buffers results in a small FIFO, counts illegal instructions.
module riscv_core_decode_stage
  import riscv_core_decode_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2,
  parameter bit EN_M  = 1'b1,
  parameter bit EN_A  = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_instr,
  input  logic [XLEN-1:0]  i_pc,
  output logic             o_valid,
  input  logic             i_ready,
  output decode_ctrl_t     o_ctrl,
  output logic [XLEN-1:0]  o_pc,
  output logic [31:0]      o_instr,
  output logic [CNT_W-1:0] o_illegal_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  decode_ctrl_t      dec_ctrl;
  decode_ctrl_t      ctrl_mem  [DEPTH];
  logic [XLEN-1:0]   pc_mem    [DEPTH];
  logic [31:0]       instr_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CW-1:0]     count;
  logic [CNT_W-1:0]  illegal_cnt;
  logic              push;
  logic              pop;

  riscv_core_decode_logic #(
    .XLEN (XLEN),
    .EN_M (EN_M),
    .EN_A (EN_A)
  ) u_decode (
    .instr (i_instr),
    .ctrl  (dec_ctrl)
  );

  // Ready depends only on occupancy, never on i_ready.
  assign o_ready = ~i_rst & (count < DEPTH_C);
  assign o_valid = (count != '0);
  assign push    = i_valid & o_ready & ~i_flush;
  assign pop     = o_valid & i_ready;

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_rst || i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; o_valid qualifies the head and the outputs are masked when empty.
  always_ff @(posedge i_clk) begin
    if (push) begin
      ctrl_mem[wr_ptr]  <= dec_ctrl;
      pc_mem[wr_ptr]    <= i_pc;
      instr_mem[wr_ptr] <= i_instr;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      illegal_cnt <= '0;
    end else if (push && dec_ctrl.illegal && (illegal_cnt != '1)) begin
      illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

  assign o_ctrl        = o_valid ? ctrl_mem[rd_ptr]  : CTRL_NOP;
  assign o_pc          = o_valid ? pc_mem[rd_ptr]    : '0;
  assign o_instr       = o_valid ? instr_mem[rd_ptr] : '0;
  assign o_illegal_cnt = illegal_cnt;

endmodule

// File: tb/tb_riscv_core_decode_stage.sv
// Self-checking bench: a 64-bit M/A stage and a 32-bit base-only stage share one stimulus stream.
module tb_riscv_core_decode_stage;
  import riscv_core_decode_pkg::*;

  localparam int DEPTH = 2;

  typedef struct {
    logic [31:0] ins;
    logic [63:0] pc;
  } ent_t;

  logic         clk = 1'b0;
  logic         rst, flush, valid, rdy;
  logic [31:0]  instr;
  logic [63:0]  pc;

  logic         ready_a, valid_a, ready_b, valid_b;
  decode_ctrl_t ctrl_a, ctrl_b;
  logic [63:0]  pc_a;
  logic [31:0]  pc_b, instr_a, instr_b;
  logic [15:0]  cnt_a;
  logic [1:0]   cnt_b;

  int unsigned  n_checks = 0;
  int unsigned  n_fail   = 0;
  ent_t         q[$];
  int unsigned  mcnt_a, mcnt_b;
  bit           last_push;

  // Read-modify-write AMOs: {funct5, amo_op}
  logic [8:0] amo_tab [9] = '{{5'b00000, AMO_ADD},  {5'b00001, AMO_SWAP}, {5'b00100, AMO_XOR},
                              {5'b01100, AMO_AND},  {5'b01000, AMO_OR},   {5'b10000, AMO_MIN},
                              {5'b10100, AMO_MAX},  {5'b11000, AMO_MINU}, {5'b11100, AMO_MAXU}};

  always #5 clk = ~clk;

  riscv_core_decode_stage #(.XLEN(64), .DEPTH(DEPTH), .EN_M(1'b1), .EN_A(1'b1), .CNT_W(16)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(ready_a),
    .i_instr(instr), .i_pc(pc), .o_valid(valid_a), .i_ready(rdy), .o_ctrl(ctrl_a),
    .o_pc(pc_a), .o_instr(instr_a), .o_illegal_cnt(cnt_a));

  riscv_core_decode_stage #(.XLEN(32), .DEPTH(DEPTH), .EN_M(1'b0), .EN_A(1'b0), .CNT_W(2)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(ready_b),
    .i_instr(instr), .i_pc(pc[31:0]), .o_valid(valid_b), .i_ready(rdy), .o_ctrl(ctrl_b),
    .o_pc(pc_b), .o_instr(instr_b), .o_illegal_cnt(cnt_b));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Field-by-field reference decode, written straight from the instruction-set rules.
  function automatic decode_ctrl_t model_decode(input logic [31:0] ins, input bit x64,
                                                input bit has_m, input bit has_a);
    decode_ctrl_t e;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [4:0] f5;
    bit is_amo, is_lr, is_sc, f5_ok, bad;
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25]; f5 = ins[31:27];
    is_amo = (opc == OPC_AMO);
    is_lr  = is_amo && (f5 == 5'b00010);
    is_sc  = is_amo && (f5 == 5'b00011);
    e = '0;
    f5_ok = is_lr || is_sc;
    foreach (amo_tab[i]) if (is_amo && amo_tab[i][8:4] == f5) begin
      e.amo_op = amo_tab[i][3:0];
      f5_ok = 1'b1;
    end
    e.regwrite = (opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OP_IMM,
                              OPC_OP_IMM_32, OPC_OP, OPC_OP_32, OPC_AMO}) ||
                 (opc == OPC_SYSTEM && f3[1:0] != 2'b00);
    e.imsrc = (opc inside {OPC_LUI, OPC_AUIPC}) ? IMM_U : (opc == OPC_JAL) ? IMM_J :
              (opc == OPC_BRANCH) ? IMM_B : (opc == OPC_STORE) ? IMM_S : IMM_I;
    e.uctrl       = (opc == OPC_AUIPC);
    e.new_mux_sel = (opc == OPC_LUI);
    e.alusrcb     = opc inside {OPC_JALR, OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP_IMM_32};
    e.memwrite    = (opc == OPC_STORE) || (is_amo && !is_lr);
    e.read        = (opc == OPC_LOAD) || (is_amo && !is_sc);
    e.resultsrc   = (opc inside {OPC_LOAD, OPC_AMO}) ? RES_MEM :
                    (opc inside {OPC_JAL, OPC_JALR}) ? RES_PC4 :
                    (opc == OPC_SYSTEM) ? RES_CSR : RES_ALU;
    e.branch  = (opc == OPC_BRANCH);
    e.aluop   = opc inside {OPC_OP_IMM, OPC_OP_IMM_32, OPC_OP, OPC_OP_32};
    e.size    = (opc inside {OPC_LOAD, OPC_STORE, OPC_AMO}) ? f3[1:0] : 2'b00;
    e.ldext   = (opc == OPC_LOAD) && f3[2];
    e.isword  = opc inside {OPC_OP_IMM_32, OPC_OP_32};
    e.jump    = opc inside {OPC_JAL, OPC_JALR};
    e.bjreg   = (opc == OPC_JALR);
    e.imsel   = (opc inside {OPC_OP, OPC_OP_32}) && (f7 == 7'b0000001);
    e.amo     = is_amo && !is_lr && !is_sc;
    e.lr      = is_lr;
    e.sc      = is_sc;
    e.src_sel = (opc == OPC_SYSTEM) && f3[2];
    e.csr_op  = (opc == OPC_SYSTEM) ? f3[1:0] : 2'b00;

    bad = !(opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE,
                        OPC_OP_IMM, OPC_OP_IMM_32, OPC_OP, OPC_OP_32, OPC_AMO, OPC_MISC_MEM, OPC_SYSTEM});
    if (opc == OPC_OP && !(f7 == 7'b0000000 || f7 == 7'b0100000 || (f7 == 7'b0000001 && has_m))) bad = 1;
    if ((opc inside {OPC_OP_32, OPC_OP_IMM_32}) && !x64) bad = 1;
    if (opc == OPC_OP_32 && f7 == 7'b0000001 && !has_m) bad = 1;
    if (is_amo && (!has_a || !(f3 inside {3'b010, 3'b011}) || (f3 == 3'b011 && !x64) || !f5_ok)) bad = 1;
    if (opc == OPC_LOAD && (f3 == 3'b111 || (!x64 && (f3 == 3'b011 || f3 == 3'b110)))) bad = 1;
    if (opc == OPC_STORE && (f3 > 3'b011 || (!x64 && f3 == 3'b011))) bad = 1;

    e.illegal = bad;
    if (bad) {e.regwrite, e.memwrite, e.branch, e.jump, e.amo, e.lr, e.sc, e.read} = '0;
    return e;
  endfunction

  // One clock: compare outputs at negedge against the model, then advance the model at posedge.
  task automatic step();
    bit do_push, do_pop;
    ent_t e;
    @(negedge clk);
    check("ready_a", ready_a, rst ? 1'b0 : (q.size() < DEPTH));
    check("ready_b", ready_b, rst ? 1'b0 : (q.size() < DEPTH));
    if (!rst) begin
      check("valid_a", valid_a, q.size() != 0);
      check("valid_b", valid_b, q.size() != 0);
      if (q.size() != 0) begin
        check("ctrl_a", ctrl_a, model_decode(q[0].ins, 1'b1, 1'b1, 1'b1));
        check("ctrl_b", ctrl_b, model_decode(q[0].ins, 1'b0, 1'b0, 1'b0));
        check("pc_a", pc_a, q[0].pc);
        check("pc_b", pc_b, q[0].pc[31:0]);
        check("instr_a", instr_a, q[0].ins);
        check("instr_b", instr_b, q[0].ins);
      end else begin
        check("empty_ctrl_a", ctrl_a, 0);
      end
      check("cnt_a", cnt_a, mcnt_a);
      check("cnt_b", cnt_b, mcnt_b);
    end
    do_push = !rst && valid && (q.size() < DEPTH) && !flush;
    do_pop  = !rst && (q.size() != 0) && rdy;
    e.ins = instr;
    e.pc  = pc;
    @(posedge clk);
    if (rst) begin
      q.delete();
      mcnt_a = 0;
      mcnt_b = 0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back(e);
        if (model_decode(e.ins, 1'b1, 1'b1, 1'b1).illegal && mcnt_a < 65535) mcnt_a++;
        if (model_decode(e.ins, 1'b0, 1'b0, 1'b0).illegal && mcnt_b < 3) mcnt_b++;
      end
    end
    last_push = do_push && !flush;
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      check("rst_ready_a", ready_a, 1'b0);
      check("rst_valid_a", valid_a, 1'b0);
      check("rst_valid_b", valid_b, 1'b0);
      check("rst_cnt_a", cnt_a, 0);
    end
    rst = 1'b0;
  endtask

  task automatic push_one(input logic [31:0] w, input logic [63:0] p);
    valid = 1'b1; instr = w; pc = p;
    step();
    valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0] opcs [15] = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE,
                              OPC_OP_IMM, OPC_OP_IMM_32, OPC_OP, OPC_OP_32, OPC_AMO, OPC_MISC_MEM,
                              OPC_SYSTEM, 7'b1111111};
    w = $urandom;
    if ($urandom_range(0, 7) != 0) w[6:0] = opcs[$urandom_range(0, 14)];
    if ($urandom_range(0, 1) == 1) begin
      case ($urandom_range(0, 2))
        0:       w[31:25] = 7'b0000000;
        1:       w[31:25] = 7'b0100000;
        default: w[31:25] = 7'b0000001;
      endcase
    end
    if (w[6:0] == OPC_AMO && $urandom_range(0, 3) != 0) begin
      w[31:27] = ($urandom_range(0, 4) == 0) ? 5'(5'b00010 + $urandom_range(0, 1))
                                             : amo_tab[$urandom_range(0, 8)][8:4];
      w[14:12] = 3'(3'b010 + $urandom_range(0, 1));
    end
    return w;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; valid = 1'b1; rdy = 1'b1;
    instr = 32'h00B50533; pc = 64'h1000;

    // Reset held with valid high
    do_reset(3);
    valid = 1'b0;
    step();
    check("post_rst_ready", ready_a, 1'b1);
    check("post_rst_ctrl", ctrl_a, 0);

    // add, then mul
    push_one(32'h00B50533, 64'h1000);
    check("add_valid", valid_a, 1'b1);
    check("add_pc", pc_a, 64'h1000);
    check("add_regwrite", ctrl_a.regwrite, 1'b1);
    check("add_alusrcb", ctrl_a.alusrcb, 1'b0);
    check("add_aluop", ctrl_a.aluop, 1'b1);
    check("add_illegal", ctrl_a.illegal, 1'b0);
    step();
    push_one(32'h02B50533, 64'h1004);
    check("mul_imsel_a", ctrl_a.imsel, 1'b1);
    check("mul_illegal_a", ctrl_a.illegal, 1'b0);
    check("mul_illegal_b", ctrl_b.illegal, 1'b1);
    check("mul_regwrite_b", ctrl_b.regwrite, 1'b0);
    step();

    // Backpressure: third instruction held upstream until the head drains
    rdy = 1'b0;
    push_one(32'h00100093, 64'h2000);
    push_one(32'h00200113, 64'h2004);
    valid = 1'b1; instr = 32'h00300193; pc = 64'h2008;
    step();
    check("bp_ready_full", ready_a, 1'b0);
    check("bp_held", last_push, 1'b0);
    step();
    check("bp_ready_full2", ready_a, 1'b0);
    rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (last_push) break;
    end
    check("bp_accept", last_push, 1'b1);
    valid = 1'b0;
    repeat (4) step();

    // 32-bit / base-only instance illegal counting
    do_reset(1);
    push_one(32'h00B5053B, 64'h3000);
    check("addw_ill_b", ctrl_b.illegal, 1'b1);
    check("addw_rw_b", ctrl_b.regwrite, 1'b0);
    check("addw_cnt_b", cnt_b, 2'd1);
    check("addw_isword_a", ctrl_a.isword, 1'b1);
    step();
    push_one(32'h00B5352F, 64'h3004);
    check("amod_ill_b", ctrl_b.illegal, 1'b1);
    check("amod_cnt_b", cnt_b, 2'd2);
    check("amod_size_a", ctrl_a.size, 2'b11);
    step();
    push_one(32'h00B5252F, 64'h3008);
    check("amow_amo", ctrl_a.amo, 1'b1);
    check("amow_op", ctrl_a.amo_op, AMO_ADD);
    check("amow_size", ctrl_a.size, 2'b10);
    check("amow_rw", ctrl_a.regwrite, 1'b1);
    step();
    push_one(32'h1005252F, 64'h300C);
    check("lrw_lr", ctrl_a.lr, 1'b1);
    check("lrw_amo", ctrl_a.amo, 1'b0);
    step();
    valid = 1'b1; instr = 32'hFFFFFFFF;
    repeat (4) step();
    valid = 1'b0;
    step();
    check("sat_cnt_b", cnt_b, 2'd3);
    check("sat_cnt_a", cnt_a, 16'd4);

    // Flush of a full FIFO with a push in the same cycle
    rdy = 1'b0;
    push_one(32'h00100093, 64'h4000);
    push_one(32'h00200113, 64'h4004);
    valid = 1'b1; instr = 32'hFFFFFFFF; flush = 1'b1;
    step();
    flush = 1'b0; valid = 1'b0;
    check("flush_valid", valid_a, 1'b0);
    check("flush_cnt_a", cnt_a, 16'd4);
    step();
    check("flush_valid2", valid_a, 1'b0);
    // Flush of an empty FIFO with an illegal push: dropped, counter untouched
    valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; valid = 1'b0;
    check("flush_drop_valid", valid_a, 1'b0);
    check("flush_drop_cnt", cnt_a, 16'd4);
    step();

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      valid = ($urandom_range(0, 3) != 0);
      rdy   = ($urandom_range(0, 1) == 1);
      flush = ($urandom_range(0, 31) == 0);
      instr = rand_instr();
      pc    = {$urandom, $urandom} & ~64'h3;
      step();
    end
    flush = 1'b0; valid = 1'b0;

    do_reset(2);
    step();
    check("final_cnt_b", cnt_b, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_core_decode_stage.md
Name: riscv_core_decode_stage

Overview:
- Registered, parametrised instruction-decode stage for the RISC-V core.
- Decodes a 32-bit instruction into a packed control bundle with refined illegal-instruction checks, selectable for XLEN 32/64 and optional M/A extensions.
- Buffers decoded results in a DEPTH-entry FIFO with valid/ready handshakes on both sides, plus flush.
- Sits between fetch and the issue/execute logic, and counts accepted illegal instructions.

Parameters:
- XLEN, 64, datapath width; only 32 or 64 are legal.
- DEPTH, 2, FIFO entries; power of two, at least 2.
- EN_M, 1, M extension enabled.
- EN_A, 1, A extension enabled.
- CNT_W, 16, width of the illegal-instruction counter.

Ports:
- i_clk  in  1  core clock
- i_rst  in  1  synchronous active-high reset
- i_flush  in  1  discard all buffered entries
- i_valid  in  1  upstream instruction valid
- o_ready  out  1  stage can accept an instruction
- i_instr  in  32  instruction word
- i_pc  in  XLEN  instruction PC
- o_valid  out  1  head entry valid
- i_ready  in  1  downstream accepts head
- o_ctrl  out  $bits(decode_ctrl_t)  decoded control bundle of head entry
- o_pc  out  XLEN  PC of head entry
- o_instr  out  32  raw instruction of head entry
- o_illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions

Behaviour:
- Control bundle fields, packed in this order:
  - regwrite 1, imsrc 3, uctrl 1, alusrcb 1, memwrite 1, resultsrc 2, branch 1, aluop 1
  - size 2, ldext 1, isword 1, jump 1, bjreg 1, imsel 1, new_mux_sel 1
  - amo 1, amo_op 4, lr 1, sc 1, src_sel 1, csr_op 2, read 1, illegal 1
  - Total 31 bits. Encodings are the package constants.
- Decode is purely combinational on i_instr. The result is written into the FIFO at the accepting edge.
- Handshake:
  - push = i_valid & o_ready & ~i_flush.
  - pop = o_valid & i_ready.
  - o_ready = ~i_rst & (count < DEPTH). There is no combinational path from i_ready to o_ready.
  - o_valid = (count != 0). o_ctrl, o_pc and o_instr come from the head entry and are stable while o_valid & ~i_ready.
- Latency: an instruction accepted at edge N is visible at the head after edge N if the FIFO was empty. FIFO order is strictly preserved.
- Simultaneous push and pop (count between 1 and DEPTH-1): count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. Count width is $clog2(DEPTH)+1.
- Flush has priority over push and pop. On flush, count and both pointers are cleared at the next edge, and any push in the same cycle is dropped. o_illegal_cnt is not affected by flush.
- Reset clears count, pointers and o_illegal_cnt. After reset o_valid=0 and o_ctrl reads all-zero. o_ready=0 while i_rst is high and 1 on the first cycle after release.
- Illegal conditions:
  - Opcode not in the supported set.
  - Opcode 0110011 with funct7 not in {0000000, 0100000, 0000001}; 0000001 is illegal when EN_M=0.
  - Opcode 0111011 or 0011011 when XLEN=32.
  - Opcode 0111011 with funct7=0000001 when EN_M=0.
  - Opcode 0101111 when EN_A=0, or funct3 not in {010, 011}, or funct3=011 with XLEN=32, or funct5 undefined.
  - Load with funct3=111, funct3=011 with XLEN=32, or funct3=110 with XLEN=32.
  - Store with funct3>011, or funct3=011 with XLEN=32.
- When illegal=1, regwrite, memwrite, branch, jump, amo, lr, sc and read are forced to 0.
- o_illegal_cnt increments on each push with illegal=1 and saturates at all-ones.

Decomposition:
- Package riscv_core_decode_pkg:
  - opcode localparams
  - decode_ctrl_t packed struct
  - amo_op, resultsrc, imsrc and csr_op encodings
  - CTRL_NOP constant (all-zero bundle)
- Sub-module riscv_core_decode_logic: combinational instruction-to-decode_ctrl_t function with parameters XLEN, EN_M and EN_A. The FIFO, handshake and counter stay in the top module.

Test Plan:
- Reset: hold i_rst for 3 cycles with i_valid=1 -> o_ready=0 and o_valid=0 during reset; cycle after release o_ready=1, o_illegal_cnt=0.
- Push add 0x00B50533 at PC 0x1000 with i_ready=1 -> next cycle o_valid=1, o_pc=0x1000, regwrite=1, alusrcb=0, aluop=1, illegal=0. Then mul 0x02B50533 -> imsel=1; with EN_M=0 -> illegal=1 and regwrite=0.
- Backpressure (DEPTH=2, i_ready=0): push 3 instructions back-to-back -> o_ready=0 after the 2nd, 3rd held upstream. Raise i_ready -> heads emerge in order 1, 2, 3 with no loss or duplication.
- XLEN=32: push addw 0x00B5053B -> illegal=1, regwrite=0, o_illegal_cnt=1. Push amoadd.d 0x00B5352F -> illegal=1, o_illegal_cnt=2.
- XLEN=64, EN_A=1: amoadd.w 0x00B5252F -> amo=1, amo_op=0001, size=10, regwrite=1. lr.w 0x1005252F -> lr=1, amo=0. CNT_W=2: push 4 illegal instructions -> counter holds at 3.
- Full FIFO, assert i_flush with i_valid=1 -> next cycle o_valid=0 and count=0; the pushed instruction is not seen at the output; o_illegal_cnt unchanged.
